// File: rtl/uart_rx_frame_if.sv
// UART receive frame bundle: serial line and frame options in, received word and status pulses out.
interface uart_rx_frame_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, data_valid, par_err, stp_err
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, data_valid, par_err, stp_err
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: oversampled start detect, majority-vote bit sampling,
// LSB-first deserialization, optional parity check and stop-bit check.
module uart_rx_frame #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OVERSAMPLE = 8
) (
   input logic             clk,
   input logic             rst,
   uart_rx_frame_if.slave  bus
);
   localparam int unsigned EW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned H  = OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [EW-1:0]         edge_q, edge_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [2:0]            samp_q, samp_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_bad_q, par_bad_d;
   logic                  valid_q, valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic rx_s;
   logic vote;
   logic decide;
   logic wrap;

   assign rx_s   = sync_q[1];
   assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign decide = (edge_q == EW'(H + 2));
   assign wrap   = (edge_q == EW'(OVERSAMPLE - 1));

   // Next-state and output computation; pulses default low every cycle.
   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[0], bus.RX_IN};
      edge_d    = edge_q;
      bit_d     = bit_q;
      samp_d    = samp_q;
      data_d    = data_q;
      p_data_d  = p_data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      par_bad_d = par_bad_q;
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;

      if (edge_q == EW'(H - 1)) samp_d[0] = rx_s;
      if (edge_q == EW'(H))     samp_d[1] = rx_s;
      if (edge_q == EW'(H + 1)) samp_d[2] = rx_s;

      if (state_q != S_IDLE) edge_d = wrap ? '0 : edge_q + EW'(1);

      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d   = S_START;
               edge_d    = '0;
               bit_d     = '0;
               par_en_d  = bus.PAR_EN;
               par_typ_d = bus.PAR_TYP;
               par_bad_d = 1'b0;
            end
         end
         S_START: begin
            if (decide && vote) begin
               state_d = S_IDLE;
               edge_d  = '0;
            end else if (wrap) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (decide) data_d[bit_q] = vote;
            if (wrap) begin
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (decide) par_bad_d = (vote != ((^data_q) ^ par_typ_q));
            if (wrap)   state_d   = S_STOP;
         end
         S_STOP: begin
            // Return to idle at the decision point so a back-to-back start bit is not missed.
            if (decide) begin
               state_d   = S_IDLE;
               edge_d    = '0;
               stp_err_d = !vote;
               par_err_d = par_bad_q;
               if (vote && !par_bad_q) begin
                  valid_d  = 1'b1;
                  p_data_d = data_q;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            edge_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sync_q    <= 2'b11;
         edge_q    <= '0;
         bit_q     <= '0;
         samp_q    <= '0;
         data_q    <= '0;
         p_data_q  <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_bad_q <= 1'b0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         samp_q    <= samp_d;
         data_q    <= data_d;
         p_data_q  <= p_data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_bad_q <= par_bad_d;
         valid_q   <= valid_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.data_valid = valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: serial frames driven at 8 clk per bit, pulses counted on the falling edge.
module tb_uart_rx_frame;
   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_frame_if #(.DATA_WIDTH(8)) bus ();

   uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_valid  = 0;
   int n_par    = 0;
   int n_stp    = 0;
   int base_v, base_p, base_s;
   logic [7:0] got_q[$];

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.data_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(bus.P_DATA);
         end
         if (bus.par_err === 1'b1) n_par++;
         if (bus.stp_err === 1'b1) n_stp++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic mark();
      base_v = n_valid;
      base_p = n_par;
      base_s = n_stp;
   endtask

   task automatic check_counts(input string tag, input int ev, input int ep, input int es);
      check({tag, "_valid"},   32'(n_valid - base_v), 32'(ev));
      check({tag, "_par_err"}, 32'(n_par - base_p),   32'(ep));
      check({tag, "_stp_err"}, 32'(n_stp - base_s),   32'(es));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      bus.RX_IN = b;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit, input logic sbit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (use_par) drive_bit(pbit);
      drive_bit(sbit);
      bus.RX_IN = 1'b1;
   endtask

   initial begin
      logic [7:0] rst_word;
      bus.RX_IN   = 1'b1;
      bus.PAR_EN  = 1'b0;
      bus.PAR_TYP = 1'b0;
      idle(3);
      check("rst_p_data",     32'(bus.P_DATA),     32'h0);
      check("rst_data_valid", 32'(bus.data_valid), 32'h0);
      check("rst_par_err",    32'(bus.par_err),    32'h0);
      check("rst_stp_err",    32'(bus.stp_err),    32'h0);
      rst = 1'b1;
      idle(5);

      // No parity, 0xA5.
      mark();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_counts("nopar_a5", 1, 0, 0);
      check("nopar_a5_p_data", 32'(bus.P_DATA), 32'hA5);

      // Even parity: 0xA5 has four ones, parity bit 0 is good, 1 is bad.
      bus.PAR_EN = 1'b1;
      bus.PAR_TYP = 1'b0;
      mark();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      idle(12);
      check_counts("even_ok", 1, 0, 0);
      check("even_ok_p_data", 32'(bus.P_DATA), 32'hA5);
      mark();
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      idle(12);
      check_counts("even_bad", 0, 1, 0);
      check("even_bad_p_data", 32'(bus.P_DATA), 32'hA5);

      // Odd parity: 0x01 has one one, parity bit 0 is good; then a low stop bit.
      bus.PAR_TYP = 1'b1;
      mark();
      send_frame(8'h01, 1'b1, 1'b0, 1'b1);
      idle(12);
      check_counts("odd_ok", 1, 0, 0);
      check("odd_ok_p_data", 32'(bus.P_DATA), 32'h01);
      mark();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      idle(24);
      check_counts("stop_low", 0, 0, 1);
      check("stop_low_p_data", 32'(bus.P_DATA), 32'h01);

      // Short glitch on the line, then a clean frame.
      bus.PAR_EN = 1'b0;
      mark();
      bus.RX_IN = 1'b0;
      idle(3);
      bus.RX_IN = 1'b1;
      idle(24);
      check_counts("glitch", 0, 0, 0);
      check("glitch_p_data", 32'(bus.P_DATA), 32'h01);
      mark();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_counts("after_glitch", 1, 0, 0);
      check("after_glitch_p_data", 32'(bus.P_DATA), 32'h3C);

      // Two frames with no idle gap.
      mark();
      got_q.delete();
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_counts("b2b", 2, 0, 0);
      check("b2b_first",  (got_q.size() >= 2) ? 32'(got_q[0]) : 32'hDEAD, 32'h55);
      check("b2b_second", (got_q.size() >= 2) ? 32'(got_q[1]) : 32'hDEAD, 32'hAA);

      // Parity options changed mid-frame are ignored until the next start bit.
      bus.PAR_EN = 1'b0;
      mark();
      fork
         begin idle(20); bus.PAR_EN = 1'b1; end
      join_none
      send_frame(8'h96, 1'b0, 1'b0, 1'b1);
      idle(12);
      bus.PAR_EN = 1'b0;
      check_counts("midframe_par_en", 1, 0, 0);
      check("midframe_par_en_p_data", 32'(bus.P_DATA), 32'h96);

      // Line stuck low for two frame times: one stop error per frame, no data.
      mark();
      bus.RX_IN = 1'b0;
      idle(162);
      bus.RX_IN = 1'b1;
      idle(120);
      check_counts("stuck_low", 0, 0, 2);
      check("stuck_low_p_data", 32'(bus.P_DATA), 32'h96);

      // Reset during data bit 4, then a clean 0x0F frame.
      rst_word = 8'h0F;
      mark();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(rst_word[i]);
      bus.RX_IN = rst_word[4];
      idle(3);
      rst = 1'b0;
      idle(1);
      check("midrst_p_data", 32'(bus.P_DATA),     32'h0);
      check("midrst_valid",  32'(bus.data_valid), 32'h0);
      bus.RX_IN = 1'b1;
      idle(4);
      rst = 1'b1;
      idle(80);
      check_counts("midrst", 0, 0, 0);
      check("midrst_p_data_hold", 32'(bus.P_DATA), 32'h0);
      mark();
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_counts("post_rst", 1, 0, 0);
      check("post_rst_p_data", 32'(bus.P_DATA), 32'h0F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
